rd_hist: RTL and testbench

Rotation-invariant uniform histogram builder for the NIRD texture path. It consumes the eight per-pixel radial-difference bits and their pixel strobe, folds each 8-bit pattern into one of 10 riu2 bins, and accumulates bin counts over a frame. On the end-of-frame pulse it drains its pipeline, streams the bins out over a valid/ready handshake, and clears the counters for the next frame.

---
 rtl/rd_hist.sv | 211 +++++++++++++++++++++
 tb/tb_rd_hist.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_hist.sv
// Rotation-invariant uniform (riu2) histogram builder with handshaked readout.
// Optional RD_HIST_TOTAL_EN adds an 11th readout word carrying the frame pixel total.
module rd_hist #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done_i,
  input  logic             progress_done_i,
  input  logic             bit1_i,
  input  logic             bit2_i,
  input  logic             bit3_i,
  input  logic             bit4_i,
  input  logic             bit5_i,
  input  logic             bit6_i,
  input  logic             bit7_i,
  input  logic             bit8_i,
  input  logic             rd_ready_i,
  output logic             hist_valid_o,
  output logic [3:0]       hist_bin_o,
  output logic [CNT_W-1:0] hist_count_o,
  output logic             hist_last_o,
  output logic             busy_o,
  output logic             overflow_o
);

`ifdef RD_HIST_TOTAL_EN
  localparam int unsigned NumWords = 11;
`else
  localparam int unsigned NumWords = 10;
`endif
  localparam logic [3:0]       LastBin = 4'(NumWords - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [1:0] {StAccum, StDrain, StReadout, StClear} state_e;

  state_e           state_q, state_d;
  logic             drain_cnt_q, drain_cnt_d;
  logic [3:0]       bin_q, bin_d;
  logic [7:0]       code_q;
  logic             vld_q;
  logic [CNT_W-1:0] cnt_q [10];
  logic [CNT_W-1:0] cnt_d [10];
  logic             ovf_q, ovf_d;
  logic [3:0]       pix_bin;
  logic             accept;
  logic [CNT_W-1:0] sel_cnt;
`ifdef RD_HIST_TOTAL_EN
  logic [CNT_W-1:0] tot_q, tot_d;
`endif

  // U counts circular transitions by comparing the code with itself rotated by one.
  function automatic logic [3:0] riu2_bin(input logic [7:0] c);
    logic [7:0] diff;
    logic [3:0] trans;
    logic [3:0] ones;
    diff  = c ^ {c[0], c[7:1]};
    trans = '0;
    ones  = '0;
    for (int i = 0; i < 8; i++) begin
      trans = trans + {3'b000, diff[i]};
      ones  = ones + {3'b000, c[i]};
    end
    return (trans <= 4'd2) ? ones : 4'd9;
  endfunction

  assign accept = done_i && (state_q == StAccum);

  // Stage 1: capture the code of an accepted pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= accept;
      if (accept) begin
        code_q <= {bit8_i, bit7_i, bit6_i, bit5_i, bit4_i, bit3_i, bit2_i, bit1_i};
      end
    end
  end

  // Stage 2: bin lookup and saturating counter update.
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    ovf_d   = ovf_q;
    pix_bin = riu2_bin(code_q);
`ifdef RD_HIST_TOTAL_EN
    tot_d = tot_q;
`endif
    if (state_q == StClear) begin
      for (int i = 0; i < 10; i++) begin
        cnt_d[i] = '0;
      end
      ovf_d = 1'b0;
`ifdef RD_HIST_TOTAL_EN
      tot_d = '0;
`endif
    end else if (vld_q) begin
      for (int i = 0; i < 10; i++) begin
        if (pix_bin == 4'(i)) begin
          if (cnt_q[i] == CntMax) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end
`ifdef RD_HIST_TOTAL_EN
      if (tot_q == CntMax) begin
        ovf_d = 1'b1;
      end else begin
        tot_d = tot_q + CNT_W'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 10; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q <= 1'b0;
`ifdef RD_HIST_TOTAL_EN
      tot_q <= '0;
`endif
    end else begin
      for (int i = 0; i < 10; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q <= ovf_d;
`ifdef RD_HIST_TOTAL_EN
      tot_q <= tot_d;
`endif
    end
  end

  // Control FSM.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    bin_d       = bin_q;
    unique case (state_q)
      StAccum: begin
        if (progress_done_i) begin
          state_d     = StDrain;
          drain_cnt_d = 1'b0;
          bin_d       = '0;
        end
      end
      StDrain: begin
        drain_cnt_d = 1'b1;
        if (drain_cnt_q) begin
          state_d = StReadout;
        end
      end
      StReadout: begin
        if (rd_ready_i) begin
          if (bin_q == LastBin) begin
            state_d = StClear;
            bin_d   = '0;
          end else begin
            bin_d = bin_q + 4'd1;
          end
        end
      end
      StClear: begin
        state_d = StAccum;
      end
      default: begin
        state_d = StAccum;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StAccum;
      drain_cnt_q <= 1'b0;
      bin_q       <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      bin_q       <= bin_d;
    end
  end

  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < 10; i++) begin
      if (bin_q == 4'(i)) begin
        sel_cnt = cnt_q[i];
      end
    end
`ifdef RD_HIST_TOTAL_EN
    if (bin_q == 4'd10) begin
      sel_cnt = tot_q;
    end
`endif
  end

  assign hist_valid_o = (state_q == StReadout);
  assign hist_bin_o   = bin_q;
  assign hist_count_o = hist_valid_o ? sel_cnt : '0;
  assign hist_last_o  = hist_valid_o && (bin_q == LastBin);
  assign busy_o       = (state_q != StAccum);
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_rd_hist.sv
// Scoreboard bench for rd_hist: a wide-counter and a 4-bit-counter instance share stimulus.
module tb_rd_hist;

`ifdef RD_HIST_TOTAL_EN
  localparam int NW = 11;
`else
  localparam int NW = 10;
`endif
  localparam int MaxL = (1 << 20) - 1;
  localparam int MaxS = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic done_i = 1'b0;
  logic progress_done_i = 1'b0;
  logic rd_ready_i = 1'b0;
  logic [7:0] code = 8'h00;

  logic v_l, last_l, busy_l, ovf_l;
  logic [3:0] b_l;
  logic [19:0] c_l;
  logic v_s, last_s, busy_s, ovf_s;
  logic [3:0] b_s;
  logic [3:0] c_s;

  always #5 clk = ~clk;

  rd_hist dut (
    .clk(clk), .rst(rst), .done_i(done_i), .progress_done_i(progress_done_i),
    .bit1_i(code[0]), .bit2_i(code[1]), .bit3_i(code[2]), .bit4_i(code[3]),
    .bit5_i(code[4]), .bit6_i(code[5]), .bit7_i(code[6]), .bit8_i(code[7]),
    .rd_ready_i(rd_ready_i), .hist_valid_o(v_l), .hist_bin_o(b_l), .hist_count_o(c_l),
    .hist_last_o(last_l), .busy_o(busy_l), .overflow_o(ovf_l)
  );

  rd_hist #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .done_i(done_i), .progress_done_i(progress_done_i),
    .bit1_i(code[0]), .bit2_i(code[1]), .bit3_i(code[2]), .bit4_i(code[3]),
    .bit5_i(code[4]), .bit6_i(code[5]), .bit7_i(code[6]), .bit8_i(code[7]),
    .rd_ready_i(rd_ready_i), .hist_valid_o(v_s), .hist_bin_o(b_s), .hist_count_o(c_s),
    .hist_last_o(last_s), .busy_o(busy_s), .overflow_o(ovf_s)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int bin;
    int cnt;
    bit ovf_l;
    bit ovf_s;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   mbin[10];
  int   mtot = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // riu2 reference: count circular bit changes, then either popcount or the non-uniform bin.
  function automatic int ref_bin(input logic [7:0] c);
    int u;
    int ones;
    u = 0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      if (c[i] != c[(i + 1) % 8]) u++;
      if (c[i]) ones++;
    end
    return (u <= 2) ? ones : 9;
  endfunction

  function automatic logic [7:0] rand_code();
    int k, r, v;
    if ($urandom_range(0, 1) == 0) return 8'($urandom);
    k = $urandom_range(0, 8);
    r = $urandom_range(0, 7);
    v = (k == 8) ? 255 : ((1 << k) - 1);
    v = ((v << r) | (v >> (8 - r))) & 255;
    return 8'(v);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 10; i++) mbin[i] = 0;
    mtot = 0;
  endtask

  task automatic model_add(input logic [7:0] c);
    mbin[ref_bin(c)]++;
    mtot++;
  endtask

  task automatic push_frame();
    exp_t e;
    bit ol, os;
    ol = 0;
    os = 0;
    for (int i = 0; i < 10; i++) begin
      if (mbin[i] > MaxL) ol = 1;
      if (mbin[i] > MaxS) os = 1;
    end
    if (NW == 11) begin
      if (mtot > MaxL) ol = 1;
      if (mtot > MaxS) os = 1;
    end
    for (int b = 0; b < NW; b++) begin
      e.bin = b;
      e.cnt = (b < 10) ? mbin[b] : mtot;
      e.ovf_l = ol;
      e.ovf_s = os;
      sbq.push_back(e);
    end
    model_clear();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input logic [7:0] c);
    done_i = 1'b1;
    code = c;
    model_add(c);
    tick();
    done_i = 1'b0;
  endtask

  task automatic end_frame(input bit with_pix, input logic [7:0] c);
    progress_done_i = 1'b1;
    if (with_pix) begin
      done_i = 1'b1;
      code = c;
      model_add(c);
    end
    push_frame();
    tick();
    progress_done_i = 1'b0;
    done_i = 1'b0;
    chk("busy_after_eof", busy_l, 1);
  endtask

  task automatic wait_word(input int b);
    for (int i = 0; i < 80; i++) begin
      if (v_l && (b_l == 4'(b))) return;
      tick();
    end
    fail_now("wait_word");
  endtask

  task automatic wait_idle(input int rmode, input bit garbage);
    for (int i = 0; i < 400; i++) begin
      if (!busy_l) begin
        done_i = 1'b0;
        progress_done_i = 1'b0;
        chk("idle_ovf_l", ovf_l, 0);
        chk("idle_ovf_s", ovf_s, 0);
        chk("idle_sb_empty", sbq.size(), 0);
        return;
      end
      rd_ready_i = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (garbage) begin
        done_i = 1'($urandom_range(0, 1));
        code = 8'($urandom);
        progress_done_i = 1'($urandom_range(0, 1));
      end
      tick();
    end
    fail_now("wait_idle");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, v_l, 0);
    chk({tag, "_bin"}, b_l, 0);
    chk({tag, "_count"}, c_l, 0);
    chk({tag, "_last"}, last_l, 0);
    chk({tag, "_busy"}, busy_l, 0);
    chk({tag, "_ovf"}, ovf_l, 0);
    chk({tag, "_valid_s"}, v_s, 0);
    chk({tag, "_count_s"}, c_s, 0);
    chk({tag, "_ovf_s"}, ovf_s, 0);
  endtask

  // Monitor: every presented word is compared with the scoreboard head; pop on handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (v_l || v_s) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got bin %0d, expected no word", b_l);
        end else begin
          mon_e = sbq[0];
          chk("mon_valid_l", v_l, 1);
          chk("mon_valid_s", v_s, 1);
          chk("mon_bin_l", b_l, mon_e.bin);
          chk("mon_bin_s", b_s, mon_e.bin);
          chk("mon_cnt_l", c_l, (mon_e.cnt > MaxL) ? MaxL : mon_e.cnt);
          chk("mon_cnt_s", c_s, (mon_e.cnt > MaxS) ? MaxS : mon_e.cnt);
          chk("mon_last_l", last_l, (mon_e.bin == NW - 1) ? 1 : 0);
          chk("mon_last_s", last_s, (mon_e.bin == NW - 1) ? 1 : 0);
          chk("mon_ovf_l", ovf_l, mon_e.ovf_l);
          chk("mon_ovf_s", ovf_s, mon_e.ovf_s);
          chk("mon_busy", busy_l, 1);
          if (rd_ready_i) void'(sbq.pop_front());
        end
      end else begin
        chk("idle_last", last_l, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    int n;
    model_clear();

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      done_i = 1'($urandom_range(0, 1));
      progress_done_i = 1'($urandom_range(0, 1));
      rd_ready_i = 1'($urandom_range(0, 1));
      code = 8'($urandom);
      tick();
      check_reset_outputs("rst_hold");
    end
    done_i = 1'b0;
    progress_done_i = 1'b0;
    rst = 1'b1;
    tick();
    chk("post_rst_busy", busy_l, 0);

    // Basic frame with timing.
    rd_ready_i = 1'b1;
    pixel(8'h00);
    pixel(8'hFF);
    pixel(8'h0F);
    pixel(8'h55);
    end_frame(1'b0, 8'h00);
    tick();
    chk("valid_t2", v_l, 0);
    tick();
    chk("valid_t3", v_l, 1);
    chk("bin_t3", b_l, 0);
    repeat (9) tick();
    chk("bin_t12", b_l, 9);
    chk("last_t12", last_l, (NW == 10) ? 1 : 0);
    wait_idle(0, 1'b0);

    // Backpressure on bin 3.
    for (int i = 0; i < 6; i++) pixel(rand_code());
    end_frame(1'b0, 8'h00);
    rd_ready_i = 1'b1;
    wait_word(3);
    rd_ready_i = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_bin", b_l, 3);
      chk("bp_valid", v_l, 1);
    end
    rd_ready_i = 1'b1;
    tick();
    chk("bp_advance", b_l, 4);
    wait_idle(0, 1'b0);

    // Pixel and end-of-frame pulses during readout are ignored.
    pixel(8'h0F);
    end_frame(1'b0, 8'h00);
    wait_word(2);
    done_i = 1'b1;
    code = 8'h00;
    progress_done_i = 1'b1;
    tick();
    done_i = 1'b0;
    progress_done_i = 1'b0;
    wait_idle(0, 1'b0);
    pixel(8'h00);
    pixel(8'h00);
    end_frame(1'b0, 8'h00);
    wait_idle(0, 1'b0);

    // Saturation of the narrow instance.
    repeat (20) pixel(8'h00);
    end_frame(1'b0, 8'h00);
    wait_word(0);
    chk("sat_ovf_s", ovf_s, 1);
    chk("sat_cnt_s", c_s, 15);
    chk("sat_cnt_l", c_l, 20);
    chk("sat_ovf_l", ovf_l, 0);
    wait_idle(0, 1'b0);

    // Reset in the middle of readout.
    for (int i = 0; i < 5; i++) pixel(rand_code());
    end_frame(1'b0, 8'h00);
    wait_word(5);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    sbq.delete();
    model_clear();
    for (int i = 0; i < 3; i++) begin
      done_i = 1'($urandom_range(0, 1));
      progress_done_i = 1'($urandom_range(0, 1));
      code = 8'($urandom);
      tick();
    end
    check_reset_outputs("mid_rst_hold");
    done_i = 1'b0;
    progress_done_i = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_release_busy", busy_l, 0);
    pixel(8'h01);
    end_frame(1'b0, 8'h00);
    wait_idle(0, 1'b0);

    // Randomized frames with gaps, random backpressure and ignored traffic while busy.
    for (int f = 0; f < 30; f++) begin
      n = $urandom_range(0, 40);
      for (int p = 0; p < n; p++) begin
        if ($urandom_range(0, 3) == 0) tick();
        pixel(rand_code());
      end
      c = rand_code();
      end_frame(1'($urandom_range(0, 1)), c);
      wait_idle(1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
